// File: rtl/score_keeper_if.sv
// score_keeper_if: bundles the game-score stage's control inputs and score outputs.
//   start, hit, over      : game controls (driven by the master side)
//   game_state            : 00=IDLE, 01=PLAY, 10=OVER
//   grade, grade_bcd      : binary score and its 3-digit BCD form
//   bcd_valid             : one-cycle pulse when grade_bcd updates
//   hiscore               : best score; exists only with SCORE_KEEPER_HISCORE_EN
// Modports: master drives the controls and observes the score; slave is the score keeper.
interface score_keeper_if;
    logic        start;
    logic        hit;
    logic        over;
    logic [1:0]  game_state;
    logic [9:0]  grade;
    logic [11:0] grade_bcd;
    logic        bcd_valid;
`ifdef SCORE_KEEPER_HISCORE_EN
    logic [9:0]  hiscore;

    modport master (
        output start, hit, over,
        input  game_state, grade, grade_bcd, bcd_valid, hiscore
    );
    modport slave (
        input  start, hit, over,
        output game_state, grade, grade_bcd, bcd_valid, hiscore
    );
`else
    modport master (
        output start, hit, over,
        input  game_state, grade, grade_bcd, bcd_valid
    );
    modport slave (
        input  start, hit, over,
        output game_state, grade, grade_bcd, bcd_valid
    );
`endif
endinterface

// File: rtl/score_keeper.sv
// score_keeper: game-score stage feeding the 7-segment driver and display renderer.
// Runs an IDLE/PLAY/OVER game FSM, accumulates a saturating binary score on each rising
// edge of the collision flag, and converts the score to 3-digit BCD with a sequential
// double-dabble engine (10 shift cycles per conversion).
// Ports:
//   sys_clk : block clock; all inputs synchronous to it
//   sys_rst : synchronous active-high reset
//   bus     : score_keeper_if.slave (start/hit/over in; game_state/grade/grade_bcd/
//             bcd_valid[/hiscore] out)
// Optional feature: define SCORE_KEEPER_HISCORE_EN to add the hiscore register/output.
module score_keeper #(
    parameter int unsigned HIT_PTS   = 1,
    parameter int unsigned GRADE_MAX = 999
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    score_keeper_if.slave bus
);

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StPlay = 2'b01;
    localparam logic [1:0] StOver = 2'b10;

    localparam logic CIdle  = 1'b0;
    localparam logic CShift = 1'b1;

    localparam logic [10:0] HitPts11   = 11'(HIT_PTS);
    localparam logic [10:0] GradeMax11 = 11'(GRADE_MAX);
    localparam logic [9:0]  GradeMax10 = 10'(GRADE_MAX);

    logic [1:0]  game_q, game_d;
    logic [9:0]  grade_q, grade_d;
    logic        hit_d_q;  // hit delayed by one cycle, for edge detection
    logic        hit_rise;
    logic [10:0] sum;
    logic [9:0]  sum_sat;
    logic        grade_changed;

    logic        conv_q, conv_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [21:0] shreg_q, shreg_d;
    logic [21:0] dabbled;
    logic        pending_q, pending_d;
    logic [11:0] grade_bcd_q, grade_bcd_d;
    logic        bcd_valid_q, bcd_valid_d;

    // One double-dabble step: bias every BCD nibble >= 5 by 3, then shift left.
    function automatic logic [21:0] dabble_step(input logic [21:0] s);
        logic [21:0] t;
        t = s;
        for (int n = 0; n < 3; n++) begin
            if (t[10+4*n +: 4] >= 4'd5) begin
                t[10+4*n +: 4] = t[10+4*n +: 4] + 4'd3;
            end
        end
        return {t[20:0], 1'b0};
    endfunction

    assign hit_rise = bus.hit & ~hit_d_q;
    assign sum      = {1'b0, grade_q} + HitPts11;
    assign sum_sat  = (sum > GradeMax11) ? GradeMax10 : sum[9:0];

    // Game FSM and score accumulation
    always_comb begin
        game_d  = game_q;
        grade_d = grade_q;
        case (game_q)
            StIdle: begin
                if (bus.start) begin
                    game_d  = StPlay;
                    grade_d = 10'd0;
                end
            end
            StPlay: begin
                // A hit on the same edge as over is still counted; over beats start.
                if (hit_rise) begin
                    grade_d = sum_sat;
                end
                if (bus.over) begin
                    game_d = StOver;
                end
            end
            StOver: begin
                if (bus.start) begin
                    game_d  = StPlay;
                    grade_d = 10'd0;
                end
            end
            default: begin
                game_d = StIdle;
            end
        endcase
    end

    assign grade_changed = (grade_d != grade_q);
    assign dabbled       = dabble_step(shreg_q);

    // BCD converter: a change that lands mid-conversion stays pending and is picked up
    // right after the current conversion finishes, so grade_bcd converges on grade.
    always_comb begin
        conv_d      = conv_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        grade_bcd_d = grade_bcd_q;
        bcd_valid_d = 1'b0;
        pending_d   = pending_q | grade_changed;
        case (conv_q)
            CIdle: begin
                if (pending_q) begin
                    shreg_d   = {12'd0, grade_q};
                    cnt_d     = 4'd0;
                    conv_d    = CShift;
                    pending_d = grade_changed;
                end
            end
            default: begin
                shreg_d = dabbled;
                cnt_d   = 4'(cnt_q + 4'd1);
                if (cnt_q == 4'd9) begin
                    grade_bcd_d = dabbled[21:10];
                    bcd_valid_d = 1'b1;
                    conv_d      = CIdle;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            game_q      <= StIdle;
            grade_q     <= 10'd0;
            hit_d_q     <= 1'b0;
            conv_q      <= CIdle;
            cnt_q       <= 4'd0;
            shreg_q     <= 22'd0;
            pending_q   <= 1'b0;
            grade_bcd_q <= 12'd0;
            bcd_valid_q <= 1'b0;
        end else begin
            game_q      <= game_d;
            grade_q     <= grade_d;
            hit_d_q     <= bus.hit;
            conv_q      <= conv_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            pending_q   <= pending_d;
            grade_bcd_q <= grade_bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign bus.game_state = game_q;
    assign bus.grade      = grade_q;
    assign bus.grade_bcd  = grade_bcd_q;
    assign bus.bcd_valid  = bcd_valid_q;

`ifdef SCORE_KEEPER_HISCORE_EN
    logic [9:0] hiscore_q, hiscore_d;

    // Captured on the PLAY->OVER edge, using the grade that includes a same-edge hit.
    always_comb begin
        hiscore_d = hiscore_q;
        if ((game_q == StPlay) && (game_d == StOver) && (grade_d > hiscore_q)) begin
            hiscore_d = grade_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hiscore_q <= 10'd0;
        end else begin
            hiscore_q <= hiscore_d;
        end
    end

    assign bus.hiscore = hiscore_q;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: two instances (HIT_PTS=1 and HIT_PTS=100) on one clock.
module tb_score_keeper;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   a_vcnt;
    int   b_vcnt;
    int   snap;

    score_keeper_if a_if ();
    score_keeper_if b_if ();

    score_keeper #(
        .HIT_PTS  (1),
        .GRADE_MAX(999)
    ) u_dut_a (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (a_if)
    );

    score_keeper #(
        .HIT_PTS  (100),
        .GRADE_MAX(999)
    ) u_dut_b (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bcd_valid pulse counters
    always @(posedge clk) begin
        if (a_if.bcd_valid) a_vcnt <= a_vcnt + 1;
        if (b_if.bcd_valid) b_vcnt <= b_vcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hit_a();
        a_if.hit = 1'b1;
        tick(1);
        a_if.hit = 1'b0;
        tick(1);
    endtask

    task automatic hit_b();
        b_if.hit = 1'b1;
        tick(1);
        b_if.hit = 1'b0;
        tick(1);
    endtask

    task automatic start_a();
        a_if.start = 1'b1;
        tick(1);
        a_if.start = 1'b0;
    endtask

    task automatic over_a();
        a_if.over = 1'b1;
        tick(1);
        a_if.over = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        a_vcnt   = 0;
        b_vcnt   = 0;
        rst      = 1'b1;
        a_if.start = 1'b0; a_if.hit = 1'b0; a_if.over = 1'b0;
        b_if.start = 1'b0; b_if.hit = 1'b0; b_if.over = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state
        check("rst_state", a_if.game_state, 2'b00);
        check("rst_grade", a_if.grade, 0);
        check("rst_bcd", a_if.grade_bcd, 12'h000);
        check("rst_valid", a_if.bcd_valid, 0);
        check("rst_grade_b", b_if.grade, 0);
`ifdef SCORE_KEEPER_HISCORE_EN
        check("rst_hiscore", a_if.hiscore, 0);
`endif

        // IDLE ignores hit and over
        hit_a();
        over_a();
        check("idle_state", a_if.game_state, 2'b00);
        check("idle_grade", a_if.grade, 0);
        tick(14);
        check("idle_no_valid", a_vcnt, 0);

        // Start: 0 -> 0 is not a change, no conversion
        start_a();
        check("start_state", a_if.game_state, 2'b01);
        check("start_grade", a_if.grade, 0);
        tick(14);
        check("start_no_valid", a_vcnt, 0);

        // Three separated hits, exact conversion latency on the last
        for (int i = 0; i < 3; i++) begin
            a_if.hit = 1'b1;
            tick(1);
            check("hit_grade", a_if.grade, i + 1);
            a_if.hit = 1'b0;
            if (i < 2) tick(14);
        end
        tick(10);
        check("lat_bcd_t10", a_if.grade_bcd, 12'h002);
        check("lat_valid_t10", a_if.bcd_valid, 0);
        tick(1);
        check("lat_bcd_t11", a_if.grade_bcd, 12'h003);
        check("lat_valid_t11", a_if.bcd_valid, 1);
        tick(1);
        check("lat_valid_t12", a_if.bcd_valid, 0);
        check("three_pulses", a_vcnt, 3);

        // start ignored in PLAY
        start_a();
        check("play_start_state", a_if.game_state, 2'b01);
        check("play_start_grade", a_if.grade, 3);

        // over, then restart
        over_a();
        check("over_state", a_if.game_state, 2'b10);
        check("over_grade", a_if.grade, 3);
        start_a();
        check("restart_grade", a_if.grade, 0);
        tick(15);
        check("restart_bcd", a_if.grade_bcd, 12'h000);

        // Two hits 4 cycles apart: second conversion queued behind the first
        a_if.hit = 1'b1;
        tick(1);
        a_if.hit = 1'b0;
        tick(3);
        a_if.hit = 1'b1;
        tick(1);
        a_if.hit = 1'b0;
        check("pair_grade", a_if.grade, 2);
        tick(7);
        check("pair_bcd1", a_if.grade_bcd, 12'h001);
        check("pair_valid1", a_if.bcd_valid, 1);
        tick(10);
        check("pair_bcd1_hold", a_if.grade_bcd, 12'h001);
        tick(1);
        check("pair_bcd2", a_if.grade_bcd, 12'h002);
        check("pair_valid2", a_if.bcd_valid, 1);

        // Run up to 41, then hit and over together
        for (int i = 0; i < 39; i++) hit_a();
        check("grade_41", a_if.grade, 41);
        a_if.hit  = 1'b1;
        a_if.over = 1'b1;
        tick(1);
        a_if.hit  = 1'b0;
        a_if.over = 1'b0;
        check("hit_over_grade", a_if.grade, 42);
        check("hit_over_state", a_if.game_state, 2'b10);
        tick(1);
        hit_a();
        hit_a();
        check("over_hold_grade", a_if.grade, 42);
        tick(30);
        check("bcd_42", a_if.grade_bcd, 12'h042);

        // Entering PLAY with hit already high does not score
        a_if.hit = 1'b1;
        tick(2);
        start_a();
        check("held_start_state", a_if.game_state, 2'b01);
        check("held_start_grade", a_if.grade, 0);
        tick(2);
        check("held_no_score", a_if.grade, 0);
        a_if.hit = 1'b0;
        tick(1);
        a_if.hit = 1'b1;
        tick(1);
        a_if.hit = 1'b0;
        check("fresh_rise_score", a_if.grade, 1);

        // start and over together in PLAY: over wins
        a_if.start = 1'b1;
        a_if.over  = 1'b1;
        tick(1);
        a_if.start = 1'b0;
        a_if.over  = 1'b0;
        check("start_over_state", a_if.game_state, 2'b10);
        check("start_over_grade", a_if.grade, 1);

        // Reset in the middle of a conversion
        start_a();
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_state", a_if.game_state, 2'b00);
        check("midrst_grade", a_if.grade, 0);
        check("midrst_bcd", a_if.grade_bcd, 12'h000);
        check("midrst_valid", a_if.bcd_valid, 0);
`ifdef SCORE_KEEPER_HISCORE_EN
        check("midrst_hiscore", a_if.hiscore, 0);
`endif
        tick(1);
        snap = a_vcnt;
        tick(15);
        check("midrst_discard", a_vcnt, snap);
        check("midrst_bcd_hold", a_if.grade_bcd, 12'h000);

`ifdef SCORE_KEEPER_HISCORE_EN
        // Game 1 ends at 7, game 2 at 5, game 3 at 9 via hit-with-over
        start_a();
        for (int i = 0; i < 7; i++) hit_a();
        over_a();
        check("hs_game1", a_if.hiscore, 7);
        start_a();
        for (int i = 0; i < 5; i++) hit_a();
        over_a();
        check("hs_game2_grade", a_if.grade, 5);
        check("hs_game2", a_if.hiscore, 7);
        start_a();
        for (int i = 0; i < 8; i++) hit_a();
        a_if.hit  = 1'b1;
        a_if.over = 1'b1;
        tick(1);
        a_if.hit  = 1'b0;
        a_if.over = 1'b0;
        check("hs_game3", a_if.hiscore, 9);
`endif

        // Saturation with HIT_PTS=100
        b_if.start = 1'b1;
        tick(1);
        b_if.start = 1'b0;
        snap = 0;
        for (int i = 0; i < 12; i++) begin
            b_if.hit = 1'b1;
            tick(1);
            if (i == 8) check("sat_900", b_if.grade, 900);
            if (i == 9) check("sat_999", b_if.grade, 999);
            b_if.hit = 1'b0;
            tick(1);
            if (i == 9) begin
                tick(30);
                check("sat_bcd", b_if.grade_bcd, 12'h999);
                snap = b_vcnt;
            end
        end
        check("sat_hold", b_if.grade, 999);
        tick(15);
        check("sat_no_conv", b_vcnt, snap);
        check("sat_bcd_final", b_if.grade_bcd, 12'h999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
